// File: rtl/cam_pixel_capture.sv
`default_nettype none
// ============================================================================
// Module      : cam_pixel_capture
// Description : OV7670 RGB565 parallel-pixel capture. Each pixel arrives as
//               two bytes: byte 1 = {R4..R0, G5..G3}, byte 2 = {G2..G0,
//               B4..B0}. Each pixel is reduced to RGB332 and written into a
//               row-major frame buffer, clipped to CAM_SCREEN_X x
//               CAM_SCREEN_Y.
//
// Ports       : clk        - camera pixel clock; all logic on its rising edge
//               rst        - asynchronous reset, active low
//               vsync      - camera VSYNC, high between frames
//               href       - camera HREF, high while line bytes are valid
//               d          - camera data D7..D0
//               ram_addr   - frame-buffer write address (y*CAM_SCREEN_X + x)
//               ram_data   - RGB332 pixel {R[2:0],G[2:0],B[1:0]}
//               ram_we     - one-cycle write strobe
//               frame_done - one-cycle pulse when a frame ends
//               busy       - high while a frame is being captured
//
// Revision    : 1.0 - initial release
// ============================================================================
module cam_pixel_capture #(
    parameter int CAM_SCREEN_X = 320,
    parameter int CAM_SCREEN_Y = 240,
    parameter int AW           = 17
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          vsync,
    input  logic          href,
    input  logic [7:0]    d,
    output logic [AW-1:0] ram_addr,
    output logic [7:0]    ram_data,
    output logic          ram_we,
    output logic          frame_done,
    output logic          busy
);

    // x and y must be able to hold the saturated value itself.
    localparam int c_x_w = $clog2(CAM_SCREEN_X + 1);
    localparam int c_y_w = $clog2(CAM_SCREEN_Y + 1);

    localparam logic [c_x_w-1:0] c_x_max  = c_x_w'(CAM_SCREEN_X);
    localparam logic [c_y_w-1:0] c_y_max  = c_y_w'(CAM_SCREEN_Y);
    localparam logic [AW-1:0]    c_line_w = AW'(CAM_SCREEN_X);

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_vblank  = 2'd1;
    localparam logic [1:0] c_st_byte_hi = 2'd2;
    localparam logic [1:0] c_st_byte_lo = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;

    logic             r_href_q;
    logic [7:0]       r_byte_hi;
    logic [c_x_w-1:0] r_x;
    logic [c_y_w-1:0] r_y;
    logic [AW-1:0]    r_line_base;

    logic [AW-1:0]    r_ram_addr;
    logic [7:0]       r_ram_data;
    logic             r_ram_we;
    logic             r_frame_done;
    logic             r_busy;

    logic             w_in_frame;
    logic             w_href_fall;
    logic             w_frame_start;
    logic             w_frame_end;
    logic             w_line_end;
    logic             w_latch_hi;
    logic             w_pixel;
    logic             w_write;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // r_href_q only follows href inside a frame, so an href left high across
    // the vsync falling edge cannot be mistaken for a line end.
    assign w_in_frame  = (r_state == c_st_byte_hi) || (r_state == c_st_byte_lo);
    assign w_href_fall = r_href_q && !href;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                // A full vsync high->low is needed before the first capture.
                if (vsync) begin
                    w_state_nxt = c_st_vblank;
                end
            end
            c_st_vblank: begin
                // Only reached with vsync high, so vsync low here is its fall.
                if (!vsync) begin
                    w_state_nxt = c_st_byte_hi;
                end
            end
            c_st_byte_hi: begin
                if (vsync) begin
                    w_state_nxt = c_st_vblank;
                end else if (href) begin
                    w_state_nxt = c_st_byte_lo;
                end
            end
            c_st_byte_lo: begin
                // Line end and pixel completion both return to BYTE_HI; a
                // line end simply drops the pending half pixel.
                if (vsync) begin
                    w_state_nxt = c_st_vblank;
                end else if (w_href_fall || href) begin
                    w_state_nxt = c_st_byte_hi;
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    // ------------------------------------------------------------------
    // Output / datapath control decode
    // ------------------------------------------------------------------
    always_comb begin
        w_frame_start = (r_state == c_st_vblank) && !vsync;
        w_frame_end   = w_in_frame && vsync;
        w_line_end    = w_in_frame && !vsync && w_href_fall;
        w_latch_hi    = (r_state == c_st_byte_hi) && !vsync && href;
        w_pixel       = (r_state == c_st_byte_lo) && !vsync && href;
        w_write       = w_pixel && (r_x < c_x_max) && (r_y < c_y_max);
    end

    // ------------------------------------------------------------------
    // Counters, pixel assembly and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_href_q     <= 1'b0;
            r_byte_hi    <= '0;
            r_x          <= '0;
            r_y          <= '0;
            r_line_base  <= '0;
            r_ram_addr   <= '0;
            r_ram_data   <= '0;
            r_ram_we     <= 1'b0;
            r_frame_done <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_href_q     <= w_in_frame ? href : 1'b0;
            r_ram_we     <= w_write;
            r_frame_done <= w_frame_end;

            if (w_frame_start) begin
                r_busy <= 1'b1;
            end else if (w_frame_end) begin
                r_busy <= 1'b0;
            end

            if (w_frame_start) begin
                r_x         <= '0;
                r_y         <= '0;
                r_line_base <= '0;
            end else if (w_line_end) begin
                r_x <= '0;
                // y saturates at CAM_SCREEN_Y; extra lines are dropped.
                if (r_y < c_y_max) begin
                    r_y         <= r_y + 1'b1;
                    r_line_base <= r_line_base + c_line_w;
                end
            end else if (w_pixel) begin
                if (r_x < c_x_max) begin
                    r_x <= r_x + 1'b1;
                end
            end

            if (w_latch_hi) begin
                r_byte_hi <= d;
            end

            // Address/data hold their last value while no write is issued.
            if (w_write) begin
                r_ram_addr <= r_line_base + AW'(r_x);
                r_ram_data <= {r_byte_hi[7:5], r_byte_hi[2:0], d[4:3]};
            end
        end
    end

    assign ram_addr   = r_ram_addr;
    assign ram_data   = r_ram_data;
    assign ram_we     = r_ram_we;
    assign frame_done = r_frame_done;
    assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_cam_pixel_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_cam_pixel_capture
// Description : Self-checking bench for cam_pixel_capture on a 4x2 screen.
//               Expected writes come from line/pixel indices and the RGB565
//               channel values, checked on every clock.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cam_pixel_capture;

    localparam int SX = 4;
    localparam int SY = 2;
    localparam int AW = 8;

    logic          clk;
    logic          rst;
    logic          vsync;
    logic          href;
    logic [7:0]    d;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_data;
    logic          ram_we;
    logic          frame_done;
    logic          busy;

    cam_pixel_capture #(
        .CAM_SCREEN_X (SX),
        .CAM_SCREEN_Y (SY),
        .AW           (AW)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .vsync      (vsync),
        .href       (href),
        .d          (d),
        .ram_addr   (ram_addr),
        .ram_data   (ram_data),
        .ram_we     (ram_we),
        .frame_done (frame_done),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    bit         capturing;
    int         line_idx;
    logic [7:0] last_addr;
    logic [7:0] last_data;
    logic [7:0] lbytes[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // RGB565 -> RGB332 by channel arithmetic.
    function automatic logic [7:0] to332(input logic [7:0] b1, input logic [7:0] b2);
        int r5, g6, b5;
        r5 = int'(b1) >> 3;
        g6 = ((int'(b1) & 7) << 3) | (int'(b2) >> 5);
        b5 = int'(b2) & 31;
        return 8'(((r5 >> 2) << 5) | ((g6 >> 3) << 2) | (b5 >> 3));
    endfunction

    // Drive inputs mid-cycle, then sample just after the next rising edge.
    task automatic step(input logic v, input logic h, input logic [7:0] dd);
        @(negedge clk);
        vsync = v;
        href  = h;
        d     = dd;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".we"},   32'(ram_we),     32'd0);
        chk({tag, ".fd"},   32'(frame_done), 32'd0);
        chk({tag, ".addr"}, 32'(ram_addr),   32'(last_addr));
        chk({tag, ".data"}, 32'(ram_data),   32'(last_data));
    endtask

    // vsync high for n cycles (href optionally noisy), then falls.
    task automatic vblank(input int n, input bit noisy);
        for (int i = 0; i < n; i++) begin
            step(1'b1, noisy ? 1'($urandom_range(0, 1)) : 1'b0, 8'($urandom));
            chk_quiet("vblank");
            chk("vblank.busy", 32'(busy), 32'd0);
        end
        step(1'b0, 1'b0, 8'($urandom));
        chk_quiet("vfall");
        chk("vfall.busy", 32'(busy), 32'd1);
        capturing = 1'b1;
        line_idx  = 0;
    endtask

    // Send lbytes as one line (href high), then gap idle cycles.
    task automatic send_line(input int gap);
        logic [7:0] hi;
        int         px;
        hi = 8'h00;
        for (int b = 0; b < lbytes.size(); b++) begin
            step(1'b0, 1'b1, lbytes[b]);
            px = b / 2;
            if ((b % 2) == 0) begin
                hi = lbytes[b];
                chk_quiet("byte1");
            end else if (capturing && px < SX && line_idx < SY) begin
                last_addr = 8'(line_idx * SX + px);
                last_data = to332(hi, lbytes[b]);
                chk("pix.we",   32'(ram_we),   32'd1);
                chk("pix.addr", 32'(ram_addr), 32'(last_addr));
                chk("pix.data", 32'(ram_data), 32'(last_data));
            end else begin
                chk_quiet("clipped");
            end
            chk("line.busy", 32'(busy), 32'(capturing));
        end
        for (int g = 0; g < gap; g++) begin
            step(1'b0, 1'b0, 8'($urandom));
            chk_quiet("gap");
        end
        line_idx++;
    endtask

    task automatic end_frame(input bit mid_line);
        step(1'b1, mid_line, 8'($urandom));
        chk("fend.fd",   32'(frame_done), 32'd1);
        chk("fend.busy", 32'(busy),       32'd0);
        chk("fend.we",   32'(ram_we),     32'd0);
        step(1'b1, 1'b0, 8'($urandom));
        chk("fend.fd2",  32'(frame_done), 32'd0);
        capturing = 1'b0;
    endtask

    task automatic fill_pattern(input int npix, input logic [7:0] b1, input logic [7:0] b2);
        lbytes.delete();
        for (int i = 0; i < npix; i++) begin
            lbytes.push_back(b1);
            lbytes.push_back(b2);
        end
    endtask

    task automatic fill_random(input int nbytes);
        lbytes.delete();
        for (int i = 0; i < nbytes; i++) lbytes.push_back(8'($urandom));
    endtask

    initial begin
        capturing = 1'b0;
        line_idx  = 0;
        last_addr = 8'h00;
        last_data = 8'h00;
        rst   = 1'b0;
        vsync = 1'b0;
        href  = 1'b0;
        d     = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.addr", 32'(ram_addr),   32'd0);
        chk("rst.data", 32'(ram_data),   32'd0);
        chk("rst.we",   32'(ram_we),     32'd0);
        chk("rst.fd",   32'(frame_done), 32'd0);
        chk("rst.busy", 32'(busy),       32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Full 4x2 frame, all white.
        vblank(3, 1'b0);
        fill_pattern(4, 8'hE7, 8'h18);
        send_line(2);
        send_line(2);
        end_frame(1'b0);

        // Over-long lines and an extra line are clipped.
        vblank(2, 1'b1);
        fill_random(12);
        send_line(1);
        fill_random(8);
        send_line(3);
        fill_random(8);
        send_line(1);
        end_frame(1'b0);

        // Half pixel dropped at line end; next line starts at line_base.
        vblank(2, 1'b0);
        fill_random(3);
        send_line(2);
        fill_random(8);
        send_line(2);
        end_frame(1'b0);

        // Colour corners.
        vblank(1, 1'b0);
        lbytes.delete();
        lbytes = '{8'hF8, 8'h00, 8'h07, 8'hE0, 8'h00, 8'h1F};
        send_line(2);
        chk("col.blue", 32'(last_data), 32'h03);
        end_frame(1'b0);

        // Asynchronous reset mid-line.
        vblank(2, 1'b0);
        fill_random(5);
        send_line(0);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("arst.addr", 32'(ram_addr),   32'd0);
        chk("arst.data", 32'(ram_data),   32'd0);
        chk("arst.we",   32'(ram_we),     32'd0);
        chk("arst.busy", 32'(busy),       32'd0);
        chk("arst.fd",   32'(frame_done), 32'd0);
        capturing = 1'b0;
        last_addr = 8'h00;
        last_data = 8'h00;
        href = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        // No vsync cycle yet: this line must be ignored.
        fill_random(8);
        send_line(2);
        vblank(2, 1'b0);
        fill_random(8);
        send_line(1);
        end_frame(1'b0);

        // Randomized frames, some aborted mid-line by vsync.
        for (int f = 0; f < 25; f++) begin
            int nl;
            vblank($urandom_range(1, 3), 1'b1);
            nl = $urandom_range(1, 4);
            for (int l = 0; l < nl; l++) begin
                fill_random($urandom_range(1, 12));
                if (l == nl - 1 && $urandom_range(0, 2) == 0) begin
                    send_line(0);
                    end_frame(1'b1);
                end else begin
                    send_line($urandom_range(1, 3));
                    if (l == nl - 1) end_frame(1'b0);
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
